pe_mac_stream: RTL and testbench

//  Dot-product PE stage placed directly downstream of two FIFO instances (ifmap, weight).

---
 rtl/pe_mac_stream.sv | 110 +++++++++++
 tb/tb_pe_mac_stream.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_mac_stream.sv
// pe_mac_stream: dot-product PE stage fed by two status-less FIFOs (ifmap, weight).
// A job starts from bias_i and adds kernel_len_i signed ifmap*weight products. The result
// is written once into a downstream psum FIFO.
//
// Ports
//   clk, rstN        clock (rising edge), asynchronous active-low reset
//   start_i          job request pulse, only acted on while idle
//   kernel_len_i     products per job, latched when start is accepted
//   bias_i           accumulator initial value, latched when start is accepted
//   ifmap_rd_en_o    read enable to ifmap FIFO
//   wgt_rd_en_o      read enable to weight FIFO (always equal to ifmap_rd_en_o)
//   ifmap_din_i      ifmap FIFO dout, valid the cycle after a read enable
//   wgt_din_i        weight FIFO dout, valid the cycle after a read enable
//   psum_wea_o       psum FIFO write enable, one pulse per job
//   psum_dout_o      psum FIFO din, registered accumulator
//   busy_o           high whenever a job is in flight
//   done_o           one-cycle pulse coincident with psum_wea_o
module pe_mac_stream #(
    parameter int unsigned DATA_BITWIDTH = 8,
    parameter int unsigned ACC_BITWIDTH  = 24,
    parameter int unsigned LEN_BITWIDTH  = 8
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     start_i,
    input  logic [LEN_BITWIDTH-1:0]  kernel_len_i,
    input  logic [ACC_BITWIDTH-1:0]  bias_i,
    output logic                     ifmap_rd_en_o,
    output logic                     wgt_rd_en_o,
    input  logic [DATA_BITWIDTH-1:0] ifmap_din_i,
    input  logic [DATA_BITWIDTH-1:0] wgt_din_i,
    output logic                     psum_wea_o,
    output logic [ACC_BITWIDTH-1:0]  psum_dout_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int unsigned ProdBits = 2 * DATA_BITWIDTH;

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StWrite} state_e;

    state_e                    state_q, state_d;
    logic [LEN_BITWIDTH-1:0]   cnt_q, cnt_d;
    logic [ACC_BITWIDTH-1:0]   acc_q, acc_d;
    logic                      rd_valid_q;
    logic                      rd_en;
    logic signed [ProdBits-1:0] ifmap_ext, wgt_ext, prod;

    // Operands are widened first so the product keeps all 2*DATA_BITWIDTH signed bits.
    always_comb begin
        ifmap_ext = ProdBits'($signed(ifmap_din_i));
        wgt_ext   = ProdBits'($signed(wgt_din_i));
        prod      = ifmap_ext * wgt_ext;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        rd_en   = 1'b0;

        // FIFO data arrives one cycle after the enable; the last product lands during DRAIN.
        // Sign-extending size cast; the sum wraps modulo 2**ACC_BITWIDTH.
        if (rd_valid_q) begin
            acc_d = acc_q + ACC_BITWIDTH'(prod);
        end

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    acc_d = bias_i;
                    cnt_d = kernel_len_i;
                    state_d = (kernel_len_i == '0) ? StWrite : StRead;
                end
            end
            StRead: begin
                rd_en = 1'b1;
                cnt_d = cnt_q - LEN_BITWIDTH'(1);
                if (cnt_q == LEN_BITWIDTH'(1)) begin
                    state_d = StDrain;
                end
            end
            StDrain: state_d = StWrite;
            StWrite: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            acc_q      <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            rd_valid_q <= rd_en;
        end
    end

    assign ifmap_rd_en_o = rd_en;
    assign wgt_rd_en_o   = rd_en;
    assign psum_wea_o    = (state_q == StWrite);
    assign done_o        = (state_q == StWrite);
    assign busy_o        = (state_q != StIdle);
    assign psum_dout_o   = acc_q;

endmodule

// File: tb/tb_pe_mac_stream.sv
// Bench for pe_mac_stream: a 24-bit and a 16-bit accumulator instance share one stimulus.
// Jobs push expected psums (value and cycle) into per-instance queues. A negedge monitor
// pops an entry and compares it whenever psum_wea is seen.
module tb_pe_mac_stream;

    localparam int DW   = 8;
    localparam int AW   = 24;
    localparam int AW16 = 16;
    localparam int LW   = 8;

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] klen = '0;
    logic [AW-1:0] bias = '0;
    logic [DW-1:0] ifmap_din = '0;
    logic [DW-1:0] wgt_din = '0;

    logic            ifmap_rd_en, wgt_rd_en, wea, done, busy;
    logic [AW-1:0]   dout;
    logic            ifmap_rd_en16, wgt_rd_en16, wea16, done16, busy16;
    logic [AW16-1:0] dout16;

    pe_mac_stream #(.DATA_BITWIDTH(DW), .ACC_BITWIDTH(AW), .LEN_BITWIDTH(LW)) dut (
        .clk(clk), .rstN(rstN), .start_i(start), .kernel_len_i(klen), .bias_i(bias),
        .ifmap_rd_en_o(ifmap_rd_en), .wgt_rd_en_o(wgt_rd_en),
        .ifmap_din_i(ifmap_din), .wgt_din_i(wgt_din),
        .psum_wea_o(wea), .psum_dout_o(dout), .busy_o(busy), .done_o(done)
    );

    pe_mac_stream #(.DATA_BITWIDTH(DW), .ACC_BITWIDTH(AW16), .LEN_BITWIDTH(LW)) dut16 (
        .clk(clk), .rstN(rstN), .start_i(start), .kernel_len_i(klen), .bias_i(bias[AW16-1:0]),
        .ifmap_rd_en_o(ifmap_rd_en16), .wgt_rd_en_o(wgt_rd_en16),
        .ifmap_din_i(ifmap_din), .wgt_din_i(wgt_din),
        .psum_wea_o(wea16), .psum_dout_o(dout16), .busy_o(busy16), .done_o(done16)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] val;
        longint        cyc;
    } exp_t;

    int     checks = 0;
    int     passes = 0;
    longint cyc = 0;
    int     wea_cnt = 0;
    int     rd_cnt = 0;
    exp_t   exp_q[$];
    exp_t   exp16_q[$];
    byte    fifo_if[$];
    byte    fifo_w[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Upstream FIFO model: one entry per read enable, presented the following cycle.
    always @(posedge clk) begin
        if (ifmap_rd_en) begin
            if (fifo_if.size() > 0) ifmap_din <= fifo_if.pop_front();
            else ifmap_din <= DW'($urandom);
        end
        if (wgt_rd_en) begin
            if (fifo_w.size() > 0) wgt_din <= fifo_w.pop_front();
            else wgt_din <= DW'($urandom);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rstN) begin
            chk("rd_en_pair", wgt_rd_en, ifmap_rd_en);
            chk("rd_en16_pair", ifmap_rd_en16, ifmap_rd_en);
            chk("done_vs_wea", done, wea);
            chk("done16_vs_wea16", done16, wea16);
            if (ifmap_rd_en) rd_cnt++;
            if (wea) begin
                wea_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL spurious_wea: psum_wea=1 at cycle %0d, required 0", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("psum_dout", dout, e.val);
                    chk("wea_cycle", cyc, e.cyc);
                end
            end
            if (wea16) begin
                if (exp16_q.size() == 0) begin
                    checks++;
                    $display("FAIL spurious_wea16: psum_wea=1 at cycle %0d, required 0", cyc);
                end else begin
                    e = exp16_q.pop_front();
                    chk("psum_dout16", dout16, e.val);
                    chk("wea16_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Reference: psum = bias + sum of signed products, reduced modulo the accumulator width.
    task automatic run_job(input int n, input logic [AW-1:0] b, input byte xi[$], input byte xw[$]);
        longint sum;
        exp_t   e;
        exp_t   e16;
        longint c1;
        int     rd_base;
        int     w0;
        int     k;
        sum = longint'(b);
        for (int i = 0; i < n; i++) begin
            fifo_if.push_back(xi[i]);
            fifo_w.push_back(xw[i]);
            sum += longint'(xi[i]) * longint'(xw[i]);
        end
        k = 0;
        @(negedge clk);
        while (busy && k < 400) begin
            @(negedge clk);
            k++;
        end
        start = 1'b1;
        klen  = LW'(n);
        bias  = b;
        @(posedge clk);
        #1;
        c1 = cyc;
        e.val  = sum[AW-1:0];
        e.cyc  = (n == 0) ? c1 : c1 + longint'(n) + 1;
        e16.val = AW'(sum[AW16-1:0]);
        e16.cyc = e.cyc;
        exp_q.push_back(e);
        exp16_q.push_back(e16);
        rd_base = rd_cnt;
        w0 = wea_cnt;
        chk("busy_after_accept", busy, 1'b1);
        chk("busy16_after_accept", busy16, 1'b1);
        // A start while busy plus changed inputs must have no effect.
        klen = LW'($urandom);
        bias = AW'($urandom);
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        while (wea_cnt == w0 && k < n + 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (wea_cnt == w0) begin
            checks++;
            $display("FAIL wea_timeout: no psum_wea within %0d cycles, required one", n + 10);
        end else begin
            chk("busy_after_write", busy, 1'b0);
            chk("busy16_after_write", busy16, 1'b0);
        end
        chk("rd_en_count", rd_cnt - rd_base, n);
    endtask

    task automatic rand_job(input int n);
        byte xi[$];
        byte xw[$];
        for (int i = 0; i < n; i++) begin
            xi.push_back(byte'($urandom));
            xw.push_back(byte'($urandom));
        end
        run_job(n, AW'($urandom), xi, xw);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_rd_en"}, {ifmap_rd_en, wgt_rd_en, ifmap_rd_en16, wgt_rd_en16}, 4'b0);
        chk({tag, "_wea"}, {wea, done, wea16, done16}, 4'b0);
        chk({tag, "_busy"}, {busy, busy16}, 2'b0);
        chk({tag, "_dout"}, {dout, dout16}, 40'h0);
    endtask

    initial begin
        byte qi[$];
        byte qw[$];

        // Reset held with start asserted.
        rstN  = 1'b0;
        start = 1'b1;
        klen  = 8'd4;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_outputs_zero("reset");
        end
        start = 1'b0;
        rstN  = 1'b1;

        // Basic job.
        qi = '{1, 2, 3, 4};
        qw = '{5, 6, 7, 8};
        run_job(4, 24'd10, qi, qw);

        // Signed extremes.
        qi = '{-128, 127};
        qw = '{-128, -1};
        run_job(2, -24'sd3, qi, qw);

        // Zero-length job returns the bias.
        qi = {};
        qw = {};
        run_job(0, 24'h00ABCD, qi, qw);

        // 16-bit accumulator wraps.
        qi = '{1, 1, 1};
        qw = '{1, 1, 1};
        run_job(3, 24'h007FFF, qi, qw);

        // 24-bit accumulator wraps.
        qi = '{127, 127};
        qw = '{127, 127};
        run_job(2, 24'hFFFFF0, qi, qw);

        // Back-to-back random jobs, including zero length.
        for (int j = 0; j < 20; j++) rand_job(int'($urandom_range(0, 12)));

        // Longest job.
        rand_job(255);

        // Abort mid-job with reset.
        for (int i = 0; i < 8; i++) begin
            fifo_if.push_back(byte'($urandom));
            fifo_w.push_back(byte'($urandom));
        end
        @(negedge clk);
        start = 1'b1;
        klen  = 8'd8;
        bias  = 24'h123456;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        rstN = 1'b0;
        #1;
        check_outputs_zero("abort");
        exp_q.delete();
        exp16_q.delete();
        fifo_if.delete();
        fifo_w.delete();
        repeat (2) begin
            @(negedge clk);
            check_outputs_zero("abort_hold");
        end
        rstN = 1'b1;
        rand_job(1);

        repeat (5) @(negedge clk);
        chk("exp_q_empty", exp_q.size(), 0);
        chk("exp16_q_empty", exp16_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1);
    end

endmodule
